// File: rtl/gshare_pattern_table.sv
// Global design parameters shared by the branch-prediction blocks, followed by the
// gshare pattern history table: 2-bit saturating counters indexed by PC XOR global
// history, with an init sweep and a 2-stage read-modify-write training pipeline.

package global_parameters;
   parameter int unsigned GLOBAL_HISTORY_WIDTH = 4;
endpackage

module gshare_pattern_table
   import global_parameters::*;
#(
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned PHT_INDEX_WIDTH = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic                            ready,
   input  logic                            pred_valid,
   input  logic [PC_WIDTH-1:0]             pred_pc,
   input  logic [GLOBAL_HISTORY_WIDTH-1:0] ghr_in,
   output logic                            pred_resp_valid,
   output logic                            pred_taken,
   output logic [1:0]                      pred_counter,
   output logic [PHT_INDEX_WIDTH-1:0]      pred_index,
   input  logic                            upd_valid,
   input  logic [PHT_INDEX_WIDTH-1:0]      upd_index,
   input  logic                            upd_taken
);

   localparam int unsigned Entries = 2 ** PHT_INDEX_WIDTH;
   localparam logic [1:0]  WeaklyNotTaken = 2'b01;

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e                     state_q;
   logic [PHT_INDEX_WIDTH-1:0] init_ptr_q;
   logic                       ready_q;

   logic                       resp_valid_q;
   logic [1:0]                 resp_counter_q;
   logic [PHT_INDEX_WIDTH-1:0] resp_index_q;

   // U2 stage registers: entry being trained and its (possibly forwarded) old value
   logic                       u2_valid_q;
   logic [PHT_INDEX_WIDTH-1:0] u2_index_q;
   logic                       u2_taken_q;
   logic [1:0]                 u2_old_q;
   logic [1:0]                 u2_new;

   logic [1:0]                 pht_mem [Entries];

   logic [PHT_INDEX_WIDTH-1:0] hist_hash;
   logic [PHT_INDEX_WIDTH-1:0] pred_idx;
   logic                       mem_we;
   logic [PHT_INDEX_WIDTH-1:0] mem_waddr;
   logic [1:0]                 mem_wdata;
   logic                       u1_fwd;
   logic                       unused_bits;

   // History folding: truncate a long history, zero-extend a short one
   generate
      if (GLOBAL_HISTORY_WIDTH >= PHT_INDEX_WIDTH) begin : g_hist_trunc
         assign hist_hash = ghr_in[PHT_INDEX_WIDTH-1:0];
      end else begin : g_hist_zext
         assign hist_hash = {{(PHT_INDEX_WIDTH - GLOBAL_HISTORY_WIDTH){1'b0}}, ghr_in};
      end
   endgenerate

   // PC bits below the word offset and above the index, plus excess history, are unused
   assign unused_bits = ^{pred_pc, ghr_in};

   assign pred_idx = pred_pc[PHT_INDEX_WIDTH+1:2] ^ hist_hash;

   // Saturating counter update for the U2 stage
   always_comb begin
      u2_new = u2_old_q;
      if (u2_taken_q) begin
         if (u2_old_q != 2'b11) u2_new = u2_old_q + 2'd1;
      end else begin
         if (u2_old_q != 2'b00) u2_new = u2_old_q - 2'd1;
      end
   end

   // Single write port: init sweep owns it in INIT, the U2 stage owns it in READY
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_ptr_q;
      mem_wdata = WeaklyNotTaken;
      if (!rst) begin
         if (state_q == StInit) begin
            mem_we = 1'b1;
         end else if (u2_valid_q) begin
            mem_we    = 1'b1;
            mem_waddr = u2_index_q;
            mem_wdata = u2_new;
         end
      end
   end

   // U1 must see the value U2 is about to commit when both hit the same entry
   assign u1_fwd = u2_valid_q && (u2_index_q == upd_index);

   // Counter storage; no reset so it maps onto RAM
   always_ff @(posedge clk) begin
      if (mem_we) pht_mem[mem_waddr] <= mem_wdata;
   end

   // Init sweep FSM: one entry per cycle, then READY until the next reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StInit;
         init_ptr_q <= '0;
         ready_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StInit: begin
               init_ptr_q <= init_ptr_q + 1'b1;
               if (&init_ptr_q) begin
                  state_q <= StReady;
                  ready_q <= 1'b1;
               end
            end
            StReady: begin
               state_q <= StReady;
            end
            default: begin
               state_q <= StInit;
            end
         endcase
      end
   end

   // Prediction response: read-before-write, so a same-edge commit is not visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q   <= 1'b0;
         resp_counter_q <= 2'b00;
         resp_index_q   <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (pred_valid && (state_q == StReady)) begin
            resp_valid_q   <= 1'b1;
            resp_counter_q <= pht_mem[pred_idx];
            resp_index_q   <= pred_idx;
         end
      end
   end

   // U1 -> U2 handoff: latch the training request and its current counter value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         u2_valid_q <= 1'b0;
         u2_index_q <= '0;
         u2_taken_q <= 1'b0;
         u2_old_q   <= 2'b00;
      end else begin
         u2_valid_q <= upd_valid && (state_q == StReady);
         if (upd_valid && (state_q == StReady)) begin
            u2_index_q <= upd_index;
            u2_taken_q <= upd_taken;
            u2_old_q   <= u1_fwd ? u2_new : pht_mem[upd_index];
         end
      end
   end

   assign ready           = ready_q;
   assign pred_resp_valid = resp_valid_q;
   assign pred_counter    = resp_counter_q;
   assign pred_taken      = resp_counter_q[1];
   assign pred_index      = resp_index_q;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// Directed bench for gshare_pattern_table with a 16-entry table and 4-bit history.
module tb_gshare_pattern_table;
   import global_parameters::*;

   localparam int unsigned PcW  = 32;
   localparam int unsigned IdxW = 4;

   logic                            clk = 1'b0;
   logic                            rst = 1'b1;
   logic                            ready;
   logic                            pred_valid = 1'b0;
   logic [PcW-1:0]                  pred_pc = '0;
   logic [GLOBAL_HISTORY_WIDTH-1:0] ghr_in = '0;
   logic                            pred_resp_valid;
   logic                            pred_taken;
   logic [1:0]                      pred_counter;
   logic [IdxW-1:0]                 pred_index;
   logic                            upd_valid = 1'b0;
   logic [IdxW-1:0]                 upd_index = '0;
   logic                            upd_taken = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   gshare_pattern_table #(
      .PC_WIDTH       (PcW),
      .PHT_INDEX_WIDTH(IdxW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ready          (ready),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .ghr_in         (ghr_in),
      .pred_resp_valid(pred_resp_valid),
      .pred_taken     (pred_taken),
      .pred_counter   (pred_counter),
      .pred_index     (pred_index),
      .upd_valid      (upd_valid),
      .upd_index      (upd_index),
      .upd_taken      (upd_taken)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle prediction request; response is checked one edge later
   task automatic predict(input logic [PcW-1:0] pc, input logic [3:0] ghr,
                          input logic [3:0] exp_idx, input logic [1:0] exp_ctr,
                          input string tag);
      pred_valid = 1'b1;
      pred_pc    = pc;
      ghr_in     = ghr;
      step();
      pred_valid = 1'b0;
      check({tag, "_vld"}, {31'd0, pred_resp_valid}, 32'd1);
      check({tag, "_idx"}, {28'd0, pred_index}, {28'd0, exp_idx});
      check({tag, "_ctr"}, {30'd0, pred_counter}, {30'd0, exp_ctr});
      check({tag, "_tkn"}, {31'd0, pred_taken}, {31'd0, exp_ctr[1]});
   endtask

   task automatic update(input logic [3:0] idx, input logic taken);
      upd_valid = 1'b1;
      upd_index = idx;
      upd_taken = taken;
      step();
      upd_valid = 1'b0;
   endtask

   // Bounded wait for ready, counting edges and any response seen meanwhile
   task automatic wait_ready(output int cyc, output int resp_seen);
      cyc       = 0;
      resp_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         cyc++;
         if (pred_resp_valid) resp_seen++;
         if (ready) break;
      end
   endtask

   initial begin
      int cyc;
      int seen;

      step();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_resp_vld", {31'd0, pred_resp_valid}, 32'd0);
      check("rst_ctr", {30'd0, pred_counter}, 32'd0);
      check("rst_idx", {28'd0, pred_index}, 32'd0);

      rst = 1'b0;
      check("ready_after_release", {31'd0, ready}, 32'd0);
      wait_ready(cyc, seen);
      check("init_cycles", cyc, 32'd16);

      predict(32'h00, 4'b0000, 4'd0, 2'b01, "p0");
      step();
      check("resp_idle", {31'd0, pred_resp_valid}, 32'd0);

      predict(32'h14, 4'b0011, 4'd6, 2'b01, "p_hash");

      // Back-to-back same-index training exercises forwarding: 01 -> 10 -> 11
      update(4'd5, 1'b1);
      update(4'd5, 1'b1);
      step();
      predict(32'h14, 4'b0000, 4'd5, 2'b11, "p_fwd");

      for (int i = 0; i < 4; i++) update(4'd2, 1'b1);
      step();
      predict(32'h08, 4'b0000, 4'd2, 2'b11, "p_sat_hi");
      for (int i = 0; i < 5; i++) update(4'd2, 1'b0);
      step();
      predict(32'h08, 4'b0000, 4'd2, 2'b00, "p_sat_lo");

      // Prediction on the edge where the index-3 write commits sees the old value
      update(4'd3, 1'b1);
      predict(32'h0C, 4'b0000, 4'd3, 2'b01, "p_rbw");
      predict(32'h0C, 4'b0000, 4'd3, 2'b10, "p_after_wr");

      // Asynchronous reset clears outputs without waiting for an edge
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", {31'd0, ready}, 32'd0);
      check("arst_ctr", {30'd0, pred_counter}, 32'd0);
      check("arst_idx", {28'd0, pred_index}, 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) step();
      check("mid_init_ready", {31'd0, ready}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Requests during INIT must be ignored
      pred_valid = 1'b1;
      pred_pc    = 32'h14;
      ghr_in     = 4'b0000;
      upd_valid  = 1'b1;
      upd_index  = 4'd0;
      upd_taken  = 1'b1;
      wait_ready(cyc, seen);
      pred_valid = 1'b0;
      upd_valid  = 1'b0;
      check("reinit_cycles", cyc, 32'd16);
      check("init_no_resp", seen, 32'd0);
      predict(32'h00, 4'b0000, 4'd0, 2'b01, "p_reinit0");
      predict(32'h14, 4'b0000, 4'd5, 2'b01, "p_reinit5");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
